// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter between a read-only lookup port (A) and a read/write refill port (B)
// sharing one single-port RAM with 1-cycle read latency; optional zero-fill sweep after reset.
module sp_ram_arbiter #(
   parameter int ADDR_WIDTH           = 6,
   parameter int DATA_WIDTH           = 64,
   parameter int INIT_MEMORY_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic [ADDR_WIDTH-1:0] a_req_addr,
   output logic                  a_rsp_valid,
   output logic [DATA_WIDTH-1:0] a_rsp_data,
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic                  b_req_we,
   input  logic [ADDR_WIDTH-1:0] b_req_addr,
   input  logic [DATA_WIDTH-1:0] b_req_wdata,
   input  logic [DATA_WIDTH-1:0] b_req_wmask,
   output logic                  b_rsp_valid,
   output logic [DATA_WIDTH-1:0] b_rsp_data,
   output logic                  ram_clk_en,
   output logic                  ram_rdw_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic [DATA_WIDTH-1:0] ram_data_mask_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  init_done
);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_INIT  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] init_idx_reg, init_idx_next;
   logic                  a_pend_reg, a_pend_next;
   logic                  b_pend_reg, b_pend_next;
   logic                  last_b_reg, last_b_next;   // 1: most recent grant went to B
   logic                  grant_a, grant_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_START;
         init_idx_reg <= '0;
         a_pend_reg   <= 1'b0;
         b_pend_reg   <= 1'b0;
         last_b_reg   <= 1'b1;
      end else begin
         state_reg    <= state_next;
         init_idx_reg <= init_idx_next;
         a_pend_reg   <= a_pend_next;
         b_pend_reg   <= b_pend_next;
         last_b_reg   <= last_b_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      init_idx_next    = init_idx_reg;
      last_b_next      = last_b_reg;
      grant_a          = 1'b0;
      grant_b          = 1'b0;
      ram_clk_en       = 1'b0;
      ram_rdw_en       = 1'b0;
      ram_addr         = '0;
      ram_data_in      = '0;
      ram_data_mask_in = '0;
      case (state_reg)
         ST_START: begin
            state_next = (INIT_MEMORY_ON_RESET != 0) ? ST_INIT : ST_RUN;
         end
         ST_INIT: begin
            ram_clk_en       = 1'b1;
            ram_rdw_en       = 1'b1;
            ram_addr         = init_idx_reg;
            ram_data_mask_in = '1;
            init_idx_next    = init_idx_reg + ADDR_WIDTH'(1);
            if (init_idx_reg == '1)
               state_next = ST_RUN;
         end
         ST_RUN: begin
            // On a tie the port that did not win last time gets the RAM.
            if (a_req_valid && (!b_req_valid || last_b_reg))
               grant_a = 1'b1;
            else if (b_req_valid)
               grant_b = 1'b1;
            if (grant_a) begin
               ram_clk_en  = 1'b1;
               ram_addr    = a_req_addr;
               last_b_next = 1'b0;
            end else if (grant_b) begin
               ram_clk_en       = 1'b1;
               ram_rdw_en       = b_req_we;
               ram_addr         = b_req_addr;
               ram_data_in      = b_req_wdata;
               ram_data_mask_in = b_req_wmask;
               last_b_next      = 1'b1;
            end
         end
         default: begin
            state_next = ST_START;
         end
      endcase
   end

   assign a_pend_next = grant_a;
   assign b_pend_next = grant_b & ~b_req_we;

   assign a_req_ready = grant_a;
   assign b_req_ready = grant_b;
   assign a_rsp_valid = a_pend_reg;
   assign b_rsp_valid = b_pend_reg;
   assign a_rsp_data  = a_pend_reg ? ram_data_out : '0;
   assign b_rsp_data  = b_pend_reg ? ram_data_out : '0;
   assign init_done   = (state_reg == ST_RUN);

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: behavioural RAM model, reset/sweep, arbitration,
// masked writes, read-after-write and reset while sweeping or with a read outstanding.
module tb_sp_ram_arbiter;
   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req_valid;
   logic [AW-1:0] a_req_addr;
   logic          b_req_valid;
   logic          b_req_we;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_req_wdata;
   logic [DW-1:0] b_req_wmask;

   logic          a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
   logic [DW-1:0] a_rsp_data, b_rsp_data;
   logic          ram_clk_en, ram_rdw_en, init_done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_in, ram_data_mask_in, ram_data_out;

   logic          u1_a_req_ready, u1_a_rsp_valid, u1_b_req_ready, u1_b_rsp_valid;
   logic [DW-1:0] u1_a_rsp_data, u1_b_rsp_data;
   logic          u1_ram_clk_en, u1_ram_rdw_en, u1_init_done;
   logic [AW-1:0] u1_ram_addr;
   logic [DW-1:0] u1_ram_data_in, u1_ram_data_mask_in;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_MEMORY_ON_RESET(1)) u0 (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
      .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wmask(b_req_wmask),
      .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
      .ram_clk_en(ram_clk_en), .ram_rdw_en(ram_rdw_en), .ram_addr(ram_addr),
      .ram_data_in(ram_data_in), .ram_data_mask_in(ram_data_mask_in),
      .ram_data_out(ram_data_out), .init_done(init_done)
   );

   // Second instance with the sweep disabled; its request inputs stay idle.
   sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_MEMORY_ON_RESET(0)) u1 (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(1'b0), .a_req_ready(u1_a_req_ready), .a_req_addr(4'd0),
      .a_rsp_valid(u1_a_rsp_valid), .a_rsp_data(u1_a_rsp_data),
      .b_req_valid(1'b0), .b_req_ready(u1_b_req_ready), .b_req_we(1'b0),
      .b_req_addr(4'd0), .b_req_wdata(32'd0), .b_req_wmask(32'd0),
      .b_rsp_valid(u1_b_rsp_valid), .b_rsp_data(u1_b_rsp_data),
      .ram_clk_en(u1_ram_clk_en), .ram_rdw_en(u1_ram_rdw_en), .ram_addr(u1_ram_addr),
      .ram_data_in(u1_ram_data_in), .ram_data_mask_in(u1_ram_data_mask_in),
      .ram_data_out(32'd0), .init_done(u1_init_done)
   );

   // Single-port RAM model: masked write, registered read.
   logic [DW-1:0] mem [2**AW];
   always @(posedge clk) begin
      if (ram_clk_en) begin
         if (ram_rdw_en)
            mem[ram_addr] <= (mem[ram_addr] & ~ram_data_mask_in) | (ram_data_in & ram_data_mask_in);
         else
            ram_data_out <= mem[ram_addr];
      end
   end

   logic [138:0] outs_all;
   assign outs_all = {a_req_ready, a_rsp_valid, a_rsp_data, b_req_ready, b_rsp_valid, b_rsp_data,
                      ram_clk_en, ram_rdw_en, ram_addr, ram_data_in, ram_data_mask_in, init_done};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      total++;
      assert (outs_all === '0) else begin
         bad++;
         $error("FAIL %s observed=%h expected=0", tag, outs_all);
      end
   endtask

   task automatic check_init_cycle(input string tag, input int k);
      check({tag, "_clk_en"}, 64'(ram_clk_en), 64'd1);
      check({tag, "_rdw_en"}, 64'(ram_rdw_en), 64'd1);
      check({tag, "_addr"}, 64'(ram_addr), 64'(k));
      check({tag, "_data"}, 64'(ram_data_in), 64'd0);
      check({tag, "_mask"}, 64'(ram_data_mask_in), 64'hFFFF_FFFF);
      check({tag, "_readies"}, 64'({a_req_ready, b_req_ready}), 64'd0);
      check({tag, "_init_done"}, 64'(init_done), 64'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      a_req_valid = 1'b0;
      a_req_addr  = '0;
      b_req_valid = 1'b0;
      b_req_we    = 1'b0;
      b_req_addr  = '0;
      b_req_wdata = '0;
      b_req_wmask = '0;
      #2;
      check_zero("in_reset");

      // Release reset with both requests already pending; they must wait out the sweep.
      @(negedge clk);
      rst_n       = 1'b1;
      a_req_valid = 1'b1;
      a_req_addr  = 4'd5;
      b_req_valid = 1'b1;
      b_req_we    = 1'b1;
      b_req_addr  = 4'd5;
      b_req_wdata = 32'hDEAD_BEEF;
      b_req_wmask = 32'hFFFF_FFFF;
      #1;
      check_zero("start_cycle");
      check("noinit_start_done", 64'(u1_init_done), 64'd0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         check_init_cycle("sweep", k);
         check("noinit_no_write", 64'(u1_ram_clk_en), 64'd0);
         if (k == 0)
            check("noinit_done_cycle2", 64'(u1_init_done), 64'd1);
      end

      // Cycle 18: first RUN cycle, A wins the tie.
      @(negedge clk); #1;
      check("run_init_done", 64'(init_done), 64'd1);
      check("tie_first_ready", 64'({a_req_ready, b_req_ready}), 64'b10);
      check("a_read_drive", 64'({ram_clk_en, ram_rdw_en, ram_addr}), 64'({2'b10, 4'd5}));

      @(negedge clk);
      a_req_valid = 1'b0;
      #1;
      check("b_write_ready", 64'({a_req_ready, b_req_ready}), 64'b01);
      check("b_write_drive", 64'({ram_clk_en, ram_rdw_en}), 64'b11);
      check("b_write_data", 64'(ram_data_in), 64'hDEAD_BEEF);
      check("a_rsp_swept", 64'({a_rsp_valid, a_rsp_data}), 64'({1'b1, 32'd0}));

      // Read-after-write on the very next cycle.
      @(negedge clk);
      b_req_valid = 1'b0;
      a_req_valid = 1'b1;
      #1;
      check("raw_a_ready", 64'(a_req_ready), 64'd1);
      check("raw_no_rsp_yet", 64'({a_rsp_valid, b_rsp_valid}), 64'd0);

      @(negedge clk);
      a_req_valid = 1'b0;
      #1;
      check("raw_a_rsp", 64'({a_rsp_valid, a_rsp_data}), 64'({1'b1, 32'hDEAD_BEEF}));
      check("idle_ram", 64'({ram_clk_en, ram_rdw_en, ram_addr}), 64'd0);

      // Masked write then B read.
      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_we    = 1'b1;
      b_req_addr  = 4'd3;
      b_req_wdata = 32'h1234_5678;
      b_req_wmask = 32'h0000_FFFF;
      #1;
      check("mask_wr_ready", 64'(b_req_ready), 64'd1);
      check("mask_wr_mask", 64'(ram_data_mask_in), 64'h0000_FFFF);

      @(negedge clk);
      b_req_we = 1'b0;
      #1;
      check("b_rd_ready", 64'(b_req_ready), 64'd1);
      check("b_rd_drive", 64'({ram_clk_en, ram_rdw_en, ram_addr}), 64'({2'b10, 4'd3}));
      check("write_no_rsp", 64'(b_rsp_valid), 64'd0);

      @(negedge clk);
      b_req_valid = 1'b0;
      #1;
      check("b_rsp_masked", 64'({b_rsp_valid, b_rsp_data}), 64'({1'b1, 32'h0000_5678}));
      check("a_quiet", 64'({a_rsp_valid, a_rsp_data}), 64'd0);

      // Continuous contention: last grant was B, so A,B,A,B,A,B.
      @(negedge clk);
      a_req_valid = 1'b1;
      a_req_addr  = 4'd5;
      b_req_valid = 1'b1;
      b_req_we    = 1'b0;
      b_req_addr  = 4'd3;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         check($sformatf("rr_ready_%0d", i), 64'({a_req_ready, b_req_ready}),
               (i % 2 == 0) ? 64'b10 : 64'b01);
         if (i > 0) begin
            if (i % 2 == 1) begin
               check($sformatf("rr_rsp_%0d", i), 64'({a_rsp_valid, a_rsp_data, b_rsp_valid}),
                     64'({1'b1, 32'hDEAD_BEEF, 1'b0}));
            end else begin
               check($sformatf("rr_rsp_%0d", i), 64'({b_rsp_valid, b_rsp_data, a_rsp_valid}),
                     64'({1'b1, 32'h0000_5678, 1'b0}));
            end
         end
      end
      @(negedge clk);
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      #1;
      check("rr_last_rsp", 64'({b_rsp_valid, b_rsp_data, a_rsp_valid}), 64'({1'b1, 32'h0000_5678, 1'b0}));

      // Reset in the middle of the sweep.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("rst_run");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_zero("restart_start");
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         check_init_cycle("sweep1", k);
      end
      rst_n = 1'b0;
      #1;
      check_zero("rst_mid_sweep");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_zero("restart2_start");
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         check_init_cycle("sweep2", k);
      end
      @(negedge clk); #1;
      check("run_again", 64'({init_done, ram_clk_en}), 64'b10);

      // Reset with an A read in flight.
      @(negedge clk);
      a_req_valid = 1'b1;
      a_req_addr  = 4'd5;
      #1;
      check("inflight_ready", 64'(a_req_ready), 64'd1);
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      check("inflight_rsp_rezeroed", 64'({a_rsp_valid, a_rsp_data}), 64'({1'b1, 32'd0}));
      rst_n = 1'b0;
      #1;
      check_zero("rst_inflight");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_zero("after_inflight_start");
      @(negedge clk); #1;
      check("after_inflight_sweep0", 64'({ram_clk_en, ram_addr, init_done, a_rsp_valid}),
            64'({1'b1, 4'd0, 1'b0, 1'b0}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
